param_snapshot: RTL and testbench

PARAM_SNAPSHOT -- requirements
Module: param_snapshot

---
 rtl/param_snapshot.sv | 163 ++++++++++++++++
 tb/tb_param_snapshot.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/param_snapshot.sv
// Frame-consistent snapshot of HPS-written camera/render parameters: inputs must
// stay quiet for STABLE_CYCLES before a frame_start may commit them to the _q outputs.

module param_snapshot_word #(
  parameter logic [31:0] RST_Q = 32'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q,
  output logic        chg,
  output logic        diff
);
  logic [31:0] prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= '0;
      q    <= RST_Q;
    end else begin
      prev <= d;
      if (load) q <= prev;
    end
  end

  assign chg  = |(d ^ prev);
  assign diff = |(prev ^ q);
endmodule

module param_snapshot #(
  parameter int STABLE_CYCLES = 1024,
  parameter int FRAC_BITS     = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic [31:0] eye_x_in,
  input  logic [31:0] eye_y_in,
  input  logic [31:0] eye_z_in,
  input  logic [31:0] lookat_1_1_in,
  input  logic [31:0] lookat_1_2_in,
  input  logic [31:0] lookat_1_3_in,
  input  logic [31:0] lookat_2_1_in,
  input  logic [31:0] lookat_2_2_in,
  input  logic [31:0] lookat_2_3_in,
  input  logic [31:0] lookat_3_1_in,
  input  logic [31:0] lookat_3_2_in,
  input  logic [31:0] lookat_3_3_in,
  input  logic [31:0] red_shift_in,
  input  logic [31:0] green_shift_in,
  input  logic [31:0] blue_shift_in,
  input  logic [31:0] fog_shift_in,
  input  logic [31:0] color_enables_in,
  input  logic [31:0] repetition_pow_in,
  output logic [31:0] eye_x_q,
  output logic [31:0] eye_y_q,
  output logic [31:0] eye_z_q,
  output logic [31:0] lookat_1_1_q,
  output logic [31:0] lookat_1_2_q,
  output logic [31:0] lookat_1_3_q,
  output logic [31:0] lookat_2_1_q,
  output logic [31:0] lookat_2_2_q,
  output logic [31:0] lookat_2_3_q,
  output logic [31:0] lookat_3_1_q,
  output logic [31:0] lookat_3_2_q,
  output logic [31:0] lookat_3_3_q,
  output logic [31:0] red_shift_q,
  output logic [31:0] green_shift_q,
  output logic [31:0] blue_shift_q,
  output logic [31:0] fog_shift_q,
  output logic [31:0] color_enables_q,
  output logic [31:0] repetition_pow_q,
  output logic        params_updated,
  output logic [15:0] skip_count,
  output logic        inputs_stable
);
  localparam int          NUM_W  = 18;
  localparam logic [15:0] STABLE = 16'(STABLE_CYCLES);
  localparam logic [31:0] ONE_FX = 32'd1 << FRAC_BITS;

  typedef enum logic [1:0] {SETTLE, READY, COMMIT} state_t;

  logic [NUM_W-1:0][31:0] in_vec, q_vec;
  logic [NUM_W-1:0]       word_chg, word_diff;
  logic                   changed, load, skip_inc, upd_pend;
  logic [15:0]            cnt;
  state_t                 state, state_nxt;

  // Word index 0 is eye_x; lookat diagonal sits at 3, 7, 11.
  assign in_vec = {repetition_pow_in, color_enables_in, fog_shift_in, blue_shift_in,
                   green_shift_in, red_shift_in, lookat_3_3_in, lookat_3_2_in,
                   lookat_3_1_in, lookat_2_3_in, lookat_2_2_in, lookat_2_1_in,
                   lookat_1_3_in, lookat_1_2_in, lookat_1_1_in, eye_z_in,
                   eye_y_in, eye_x_in};

  assign {repetition_pow_q, color_enables_q, fog_shift_q, blue_shift_q,
          green_shift_q, red_shift_q, lookat_3_3_q, lookat_3_2_q,
          lookat_3_1_q, lookat_2_3_q, lookat_2_2_q, lookat_2_1_q,
          lookat_1_3_q, lookat_1_2_q, lookat_1_1_q, eye_z_q,
          eye_y_q, eye_x_q} = q_vec;

  generate
    for (genvar i = 0; i < NUM_W; i++) begin : g_word
      param_snapshot_word #(
        .RST_Q((i == 3 || i == 7 || i == 11) ? ONE_FX : 32'd0)
      ) u_word (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (load),
        .d      (in_vec[i]),
        .q      (q_vec[i]),
        .chg    (word_chg[i]),
        .diff   (word_diff[i])
      );
    end
  endgenerate

  assign changed = |word_chg;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    skip_inc  = 1'b0;
    case (state)
      SETTLE: begin
        skip_inc = frame_start;
        if (cnt == STABLE && !changed) state_nxt = READY;
      end
      READY: begin
        if (changed) begin
          state_nxt = SETTLE;
          skip_inc  = frame_start;
        end else if (frame_start) begin
          state_nxt = COMMIT;
          load      = 1'b1;
        end
      end
      COMMIT:  state_nxt = changed ? SETTLE : READY;
      default: state_nxt = SETTLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= SETTLE;
      cnt            <= '0;
      skip_count     <= '0;
      upd_pend       <= 1'b0;
      params_updated <= 1'b0;
      inputs_stable  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (changed)            cnt <= '0;
      else if (cnt != STABLE) cnt <= cnt + 16'd1;
      if (skip_inc && skip_count != 16'hFFFF) skip_count <= skip_count + 16'd1;
      // Remember at load time whether any word will actually move.
      if (load) upd_pend <= |word_diff;
      params_updated <= (state == COMMIT) && upd_pend;
      inputs_stable  <= (cnt == STABLE);
    end
  end
endmodule

// File: tb/tb_param_snapshot.sv
// Directed + randomized bench for param_snapshot, checked every cycle against a
// behavioural model of the commit/skip rules.

module tb_param_snapshot;
  localparam int S = 1024;

  logic clk = 1'b0;
  logic reset_n;
  logic frame_start;
  logic [17:0][31:0] in_v;
  logic [31:0] q_w [18];
  logic params_updated, inputs_stable;
  logic [15:0] skip_count;

  int vecs = 0;
  int miss = 0;

  logic [17:0][31:0] m_last, m_q;
  int   m_quiet;
  bit   m_ready, m_commit, m_pend, m_upd, m_stable;
  logic [15:0] m_skip;

  always #5 clk = ~clk;

  param_snapshot dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
    .eye_x_in(in_v[0]), .eye_y_in(in_v[1]), .eye_z_in(in_v[2]),
    .lookat_1_1_in(in_v[3]), .lookat_1_2_in(in_v[4]), .lookat_1_3_in(in_v[5]),
    .lookat_2_1_in(in_v[6]), .lookat_2_2_in(in_v[7]), .lookat_2_3_in(in_v[8]),
    .lookat_3_1_in(in_v[9]), .lookat_3_2_in(in_v[10]), .lookat_3_3_in(in_v[11]),
    .red_shift_in(in_v[12]), .green_shift_in(in_v[13]), .blue_shift_in(in_v[14]),
    .fog_shift_in(in_v[15]), .color_enables_in(in_v[16]), .repetition_pow_in(in_v[17]),
    .eye_x_q(q_w[0]), .eye_y_q(q_w[1]), .eye_z_q(q_w[2]),
    .lookat_1_1_q(q_w[3]), .lookat_1_2_q(q_w[4]), .lookat_1_3_q(q_w[5]),
    .lookat_2_1_q(q_w[6]), .lookat_2_2_q(q_w[7]), .lookat_2_3_q(q_w[8]),
    .lookat_3_1_q(q_w[9]), .lookat_3_2_q(q_w[10]), .lookat_3_3_q(q_w[11]),
    .red_shift_q(q_w[12]), .green_shift_q(q_w[13]), .blue_shift_q(q_w[14]),
    .fog_shift_q(q_w[15]), .color_enables_q(q_w[16]), .repetition_pow_q(q_w[17]),
    .params_updated(params_updated), .skip_count(skip_count),
    .inputs_stable(inputs_stable)
  );

  task automatic model_reset();
    m_last   = '0;
    m_quiet  = 0;
    m_ready  = 1'b0;
    m_commit = 1'b0;
    m_pend   = 1'b0;
    m_upd    = 1'b0;
    m_stable = 1'b0;
    m_skip   = 16'd0;
    m_q      = '0;
    m_q[3]   = 32'h0001_0000;
    m_q[7]   = 32'h0001_0000;
    m_q[11]  = 32'h0001_0000;
  endtask

  // Rules: quiet run of S cycles arms the block; an armed, unchanged frame_start
  // commits; any other frame_start outside the commit cycle is a refused frame.
  task automatic model_step();
    bit chg, commit_now, refused, nu, ns;
    chg        = (in_v != m_last);
    nu         = m_commit && m_pend;
    ns         = (m_quiet == S);
    commit_now = m_ready && frame_start && !chg;
    refused    = frame_start && !m_commit && !commit_now;
    if (refused && m_skip != 16'hFFFF) m_skip = m_skip + 16'd1;
    if (commit_now) begin
      m_pend = (m_q != in_v);
      m_q    = in_v;
    end
    if (m_commit) begin
      m_commit = 1'b0;
      m_ready  = !chg;
    end else if (commit_now) begin
      m_commit = 1'b1;
      m_ready  = 1'b0;
    end else if (m_ready) begin
      m_ready = !chg;
    end else begin
      m_ready = (m_quiet == S) && !chg;
    end
    m_quiet  = chg ? 0 : ((m_quiet < S) ? m_quiet + 1 : S);
    m_last   = in_v;
    m_upd    = nu;
    m_stable = ns;
  endtask

  task automatic check_outputs();
    logic [17:0][31:0] qp;
    for (int i = 0; i < 18; i++) qp[i] = q_w[i];
    vecs++;
    assert (qp === m_q) else begin
      miss++; $error("FAIL q_words got %h exp %h", qp, m_q);
    end
    vecs++;
    assert (params_updated === m_upd) else begin
      miss++; $error("FAIL params_updated got %b exp %b", params_updated, m_upd);
    end
    vecs++;
    assert (skip_count === m_skip) else begin
      miss++; $error("FAIL skip_count got %h exp %h", skip_count, m_skip);
    end
    vecs++;
    assert (inputs_stable === m_stable) else begin
      miss++; $error("FAIL inputs_stable got %b exp %b", inputs_stable, m_stable);
    end
  endtask

  task automatic expect32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      miss++; $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic fs);
    frame_start = fs;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
    frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0);
  endtask

  initial begin
    logic [31:0] old_l12, new_l12;
    reset_n     = 1'b0;
    frame_start = 1'b0;
    in_v        = '0;
    #12;
    model_reset();
    check_outputs();
    expect32("rst_lookat_2_2", q_w[7], 32'h0001_0000);
    @(negedge clk);
    reset_n = 1'b1;

    // First commit of a fresh parameter set
    for (int i = 0; i < 18; i++) in_v[i] = $urandom;
    in_v[0] = 32'h0002_0000;
    idle(S + 6);
    step(1'b1);
    expect32("commit_eye_x", q_w[0], 32'h0002_0000);
    step(1'b0);
    expect32("first_pulse", {31'd0, params_updated}, 32'd1);
    expect32("first_skip", {16'd0, skip_count}, 32'd0);

    // Identical re-commit: no movement, no pulse
    idle(3);
    step(1'b1);
    step(1'b0);
    expect32("same_pulse", {31'd0, params_updated}, 32'd0);

    // Late change refuses the frame, later quiet frame commits it
    old_l12 = in_v[4];
    new_l12 = old_l12 ^ 32'h1234_5678;
    in_v[4] = new_l12;
    idle(10);
    step(1'b1);
    expect32("late_q_hold", q_w[4], old_l12);
    expect32("late_skip", {16'd0, skip_count}, 32'd1);
    idle(S + 6);
    step(1'b1);
    expect32("late_commit", q_w[4], new_l12);

    // Change coincident with frame_start in READY
    idle(3);
    in_v[0] = in_v[0] + 32'd1;
    step(1'b1);
    expect32("coinc_skip", {16'd0, skip_count}, 32'd2);
    step(1'b0);
    step(1'b1);
    expect32("settle_skip", {16'd0, skip_count}, 32'd3);

    // Randomized episodes around the settle boundary
    for (int ep = 0; ep < 6; ep++) begin
      int nchg, quiet;
      nchg = $urandom_range(1, 3);
      for (int c = 0; c < nchg; c++) begin
        in_v[$urandom_range(0, 17)] = $urandom;
        step($urandom_range(0, 7) == 0);
      end
      quiet = $urandom_range(S - 2, S + 4);
      for (int k = 0; k < quiet; k++) step($urandom_range(0, 63) == 0);
      step(1'b1);
      idle(2);
    end

    // Reset during the commit cycle
    for (int i = 0; i < 18; i++) in_v[i] = $urandom | 32'h8000_0000;
    idle(S + 6);
    step(1'b1);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    expect32("abort_diag", q_w[11], 32'h0001_0000);
    expect32("abort_eye_x", q_w[0], 32'd0);
    expect32("abort_pulse", {31'd0, params_updated}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(3);

    // Saturate the refused-frame counter
    for (int k = 0; k < 70000; k++) begin
      in_v[1] = in_v[1] ^ 32'd1;
      step(1'b1);
    end
    expect32("skip_sat", {16'd0, skip_count}, 32'h0000_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
